zigzag_rle: RTL
===============

Name: zigzag_rle

Overview:
- Stage directly downstream of the quantizer in the MJPEG datapath.
- Accepts one 8x8 block of quantized coefficients in raster order and stores it in an internal 64-entry buffer.
- Re-reads the block in JPEG zigzag order and emits (run, value) symbols with DC, ZRL and EOB handling.
- Feeds the future Huffman/entropy stage through a valid/ready handshake.

Parameters:
- DW, 8, coefficient width (signed two's complement), for both in_data and out_value.
- RW, 4, run-length field width; fixed at 4 for JPEG, exposed only for the bench.

Ports:
- clk  in  1  system clock (clk_wiz clk_out1 domain)
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  DW  quantized coefficient, raster order, index 0 = DC
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts input; high only in FILL
- out_run  out  RW  zero-run preceding out_value
- out_value  out  DW  coefficient value (0 for ZRL/EOB)
- out_is_dc  out  1  symbol is the DC coefficient
- out_last  out  1  final symbol of the block
- out_valid  out  1  symbol valid
- out_ready  in  1  downstream accepts symbol
- block_done  out  1  one-cycle pulse after the last symbol of a block is accepted

Behaviour:
- Reset (async, active-high), all outputs 0:
  - state=FILL, write counter=0, run=0, last_nz=0.
  - in_ready goes high on the first clk after reset deasserts.
- FILL:
  - Each in_valid && in_ready cycle writes in_data to buf[wr_cnt] and increments wr_cnt (6 bits).
  - If in_data != 0, a combinational raster->zigzag ROM gives zz(wr_cnt); last_nz <= max(last_nz, zz).
  - On the 64th accept (wr_cnt==63): in_ready drops the next cycle and state goes to SCAN.
- SCAN:
  - Registered read of buf[zigzag_to_raster(idx)], idx = 0..63.
  - First out_valid no later than 2 cycles after the 64th input accept.
  - While not stalled, one index is examined per cycle.
  - idx 0: emit (0, value, is_dc=1) regardless of value.
  - idx 1..63, coefficient nonzero: emit (run, value); run <= 0.
  - idx 1..63, coefficient zero, idx > last_nz: no more symbols except EOB. Emit EOB (0,0) with out_last=1.
  - Otherwise, zero coefficient:
    - run==15 and idx < last_nz: emit ZRL (15,0); run <= 0.
    - else run <= run+1, with no output.
  - Nonzero at idx 63: emitted with out_last=1 and no EOB.
  - All-zero AC (last_nz==0): DC symbol, then EOB.
- Handshake:
  - A symbol transfers on out_valid && out_ready.
  - While out_valid && !out_ready, all out_* hold stable and scanning stalls.
  - out_valid never deasserts without a transfer.
- DONE:
  - Entered after the out_last symbol transfers.
  - block_done=1 for exactly one cycle; state returns to FILL; wr_cnt, run and last_nz are cleared.
  - in_ready is high the following cycle.
- Input while not in FILL:
  - in_ready=0; in_data is ignored and nothing is lost internally; the upstream must hold.
- Reset mid-FILL or mid-SCAN:
  - Immediate abort; the partial block is discarded and no block_done is produced.
- Arithmetic:
  - out_value is the stored coefficient, unmodified.
  - run never exceeds 15.
  - Symbols per block: 2 minimum, 64 maximum.

Optional Feature:
- Macro: ZIGZAG_RLE_STATS_EN.
- When defined, adds two outputs:
  - sym_count[6:0]: symbols emitted in the last completed block, updated on block_done.
  - blk_count[15:0]: completed blocks, wrapping at 65535->0.
  - Both reset to 0.
- When undefined, neither port nor its counters exists; all other behaviour is identical.

Test Plan:
- All 64 inputs 0, out_ready=1 -> exactly 2 symbols: (0,0,dc=1), then EOB (0,0,last=1); block_done pulses once; then in_ready=1.
- DC=5, raster[1]=-3 (0xFD), rest 0 -> (0,0x05,dc=1), (0,0xFD), EOB (0,0,last=1).
- DC=0, raster[63]=7 (zz63), rest 0 -> DC, ZRL x3 at zz16/32/48, then (14,7,last=1); no EOB; 5 symbols.
- DC=0, zz17=4, rest 0 -> DC, ZRL (15,0), (0,4), EOB; 4 symbols.
- Block of scenario 2, out_ready held 0 for 5 cycles while (0,0xFD) is presented -> out_run, out_value and out_valid stable throughout; sequence unchanged after release.
- in_valid=1 with data 0x11 during SCAN -> in_ready=0 and the next block is unaffected.
- reset pulse at the 3rd symbol -> outputs 0 immediately, no block_done; the next full block encodes correctly.

Source files
------------

// File: rtl/zigzag_rle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : zigzag_rle                                                       |
// | Purpose  : Buffers one 8x8 block of quantized coefficients (raster order),  |
// |            re-reads it in JPEG zigzag order and emits (run, value) symbols  |
// |            with DC, ZRL and EOB handling over a valid/ready interface.      |
// | Options  : ZIGZAG_RLE_STATS_EN adds sym_count / blk_count outputs.          |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module zigzag_rle #(
  parameter int DW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [RW-1:0] out_run,
  output logic [DW-1:0] out_value,
  output logic          out_is_dc,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          block_done
`ifdef ZIGZAG_RLE_STATS_EN
  ,
  output logic [6:0]    sym_count,
  output logic [15:0]   blk_count
`endif
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [RW-1:0] c_run_max = '1;

  // Raster position -> zigzag position, derived from the anti-diagonal the
  // coefficient sits on: odd diagonals are walked top-right to bottom-left,
  // even diagonals bottom-left to top-right.
  function automatic logic [5:0] raster_to_zz(input logic [5:0] a);
    logic [6:0] r, c, d, lo, base, pos;
    r = {4'd0, a[5:3]};
    c = {4'd0, a[2:0]};
    d = r + c;
    if (d < 7'd8) begin
      base = (d * (d + 7'd1)) >> 1;
      lo   = 7'd0;
    end else begin
      base = 7'd64 - (((7'd15 - d) * (7'd16 - d)) >> 1);
      lo   = d - 7'd7;
    end
    pos = d[0] ? (r - lo) : (c - lo);
    return 6'(base + pos);
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    wr_cnt_q, wr_cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [RW-1:0] run_q, run_d;
  logic [5:0]    last_nz_q, last_nz_d;
  logic          fin_q, fin_d;
  logic          in_ready_q, in_ready_d;
  logic [RW-1:0] out_run_q, out_run_d;
  logic [DW-1:0] out_value_q, out_value_d;
  logic          out_is_dc_q, out_is_dc_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;
  logic          block_done_q, block_done_d;

  // The buffer is written at the zigzag address of each raster sample, so the
  // scan simply walks it linearly (same result as reading via zigzag_to_raster).
  logic [DW-1:0] mem_q [64];

  logic          w_accept;
  logic [5:0]    w_zz;
  logic [DW-1:0] w_coef;
  logic          w_out_free;
  logic          w_xfer;

  assign w_accept   = in_valid && in_ready_q;
  assign w_zz       = raster_to_zz(wr_cnt_q);
  assign w_coef     = mem_q[idx_q];
  assign w_xfer     = out_valid_q && out_ready;
  assign w_out_free = !out_valid_q || out_ready;

  // Coefficient buffer: plain storage, contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (w_accept) mem_q[w_zz] <= in_data;
  end

  // Next-state and symbol generation.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    idx_d        = idx_q;
    run_d        = run_q;
    last_nz_d    = last_nz_q;
    fin_d        = fin_q;
    out_run_d    = out_run_q;
    out_value_d  = out_value_q;
    out_is_dc_d  = out_is_dc_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q && !out_ready;
    block_done_d = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (in_data != '0 && w_zz > last_nz_q) last_nz_d = w_zz;
          if (wr_cnt_q == 6'd63) begin
            state_d = ST_SCAN;
            idx_d   = 6'd0;
            run_d   = '0;
            fin_d   = 1'b0;
          end
        end
      end
      ST_SCAN: begin
        if (w_xfer && out_last_q) begin
          state_d      = ST_DONE;
          block_done_d = 1'b1;
        end else if (!fin_q && w_out_free) begin
          out_is_dc_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == 6'd0) begin
            // DC is always emitted, even when zero.
            out_valid_d = 1'b1;
            out_run_d   = '0;
            out_value_d = w_coef;
            out_is_dc_d = 1'b1;
            idx_d       = 6'd1;
          end else if (w_coef != '0) begin
            out_valid_d = 1'b1;
            out_run_d   = run_q;
            out_value_d = w_coef;
            out_last_d  = (idx_q == 6'd63);
            fin_d       = (idx_q == 6'd63);
            run_d       = '0;
            idx_d       = idx_q + 6'd1;
          end else if (idx_q > last_nz_q) begin
            // Only zeros remain: close the block with EOB.
            out_valid_d = 1'b1;
            out_run_d   = '0;
            out_value_d = '0;
            out_last_d  = 1'b1;
            fin_d       = 1'b1;
          end else if (run_q == c_run_max) begin
            // Sixteenth zero with a nonzero still ahead: ZRL.
            out_valid_d = 1'b1;
            out_run_d   = c_run_max;
            out_value_d = '0;
            run_d       = '0;
            idx_d       = idx_q + 6'd1;
          end else begin
            run_d = run_q + 1'b1;
            idx_d = idx_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_FILL;
        wr_cnt_d  = 6'd0;
        idx_d     = 6'd0;
        run_d     = '0;
        last_nz_d = 6'd0;
        fin_d     = 1'b0;
      end
      default: state_d = ST_FILL;
    endcase
    in_ready_d = (state_d == ST_FILL);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wr_cnt_q     <= 6'd0;
      idx_q        <= 6'd0;
      run_q        <= '0;
      last_nz_q    <= 6'd0;
      fin_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_run_q    <= '0;
      out_value_q  <= '0;
      out_is_dc_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      idx_q        <= idx_d;
      run_q        <= run_d;
      last_nz_q    <= last_nz_d;
      fin_q        <= fin_d;
      in_ready_q   <= in_ready_d;
      out_run_q    <= out_run_d;
      out_value_q  <= out_value_d;
      out_is_dc_q  <= out_is_dc_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      block_done_q <= block_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_run    = out_run_q;
  assign out_value  = out_value_q;
  assign out_is_dc  = out_is_dc_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;
  assign block_done = block_done_q;

`ifdef ZIGZAG_RLE_STATS_EN
  logic [6:0]  sym_cnt_q, sym_cnt_d;
  logic [6:0]  sym_count_q, sym_count_d;
  logic [15:0] blk_count_q, blk_count_d;

  // Per-block symbol tally, latched together with the block_done pulse.
  always_comb begin
    sym_cnt_d   = sym_cnt_q;
    sym_count_d = sym_count_q;
    blk_count_d = blk_count_q;
    if (w_xfer) begin
      if (out_last_q) begin
        sym_count_d = sym_cnt_q + 7'd1;
        blk_count_d = blk_count_q + 16'd1;
        sym_cnt_d   = 7'd0;
      end else begin
        sym_cnt_d = sym_cnt_q + 7'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt_q   <= 7'd0;
      sym_count_q <= 7'd0;
      blk_count_q <= 16'd0;
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      sym_count_q <= sym_count_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign sym_count = sym_count_q;
  assign blk_count = blk_count_q;
`endif

endmodule
`default_nettype wire
